// File: rtl/mem_lsu_master_pkg.sv
// rtl/mem_lsu_master_pkg.sv - size encodings, FSM states and access-size helper for the load/store master
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RMW  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    // Byte count of an access; the illegal size 3 is faulted separately.
    function automatic logic [32:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 33'd1;
            SZ_HALF: return 33'd2;
            default: return 33'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_master_if.sv
// rtl/mem_lsu_master_if.sv - core request/response and RAM strobe bundle with master/slave views
interface mem_lsu_master_if;
    logic        iLSU_REQ_VALID;
    logic        oLSU_REQ_READY;
    logic        iLSU_REQ_WE;
    logic [1:0]  iLSU_REQ_SIZE;
    logic        iLSU_REQ_UNSIGNED;
    logic [31:0] iLSU_REQ_ADDR;
    logic [31:0] iLSU_REQ_WDATA;
    logic        oLSU_RSP_VALID;
    logic        iLSU_RSP_READY;
    logic [31:0] oLSU_RSP_RDATA;
    logic        oLSU_RSP_ERR;
    logic        oRAM_CE;
    logic        oRAM_RD;
    logic        oRAM_WR;
    logic [31:0] oRAM_ADDR;
    logic [31:0] oRAM_DATA;
    logic [31:0] iRAM_DATA;

    modport master (
        input  iLSU_REQ_VALID, iLSU_REQ_WE, iLSU_REQ_SIZE, iLSU_REQ_UNSIGNED,
        input  iLSU_REQ_ADDR, iLSU_REQ_WDATA, iLSU_RSP_READY, iRAM_DATA,
        output oLSU_REQ_READY, oLSU_RSP_VALID, oLSU_RSP_RDATA, oLSU_RSP_ERR,
        output oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
    );

    modport slave (
        output iLSU_REQ_VALID, iLSU_REQ_WE, iLSU_REQ_SIZE, iLSU_REQ_UNSIGNED,
        output iLSU_REQ_ADDR, iLSU_REQ_WDATA, iLSU_RSP_READY, iRAM_DATA,
        input  oLSU_REQ_READY, oLSU_RSP_VALID, oLSU_RSP_RDATA, oLSU_RSP_ERR,
        input  oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
    );
endinterface

// File: rtl/mem_lsu_master_data_align.sv
// rtl/mem_lsu_master_data_align.sv - combinational little-endian lane extract/extend and sub-word store merge
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    function automatic logic [31:0] load_extract(input logic [1:0] lane, input logic [1:0] size,
                                                 input logic uns, input logic [31:0] rword);
        logic [7:0]  w_byte;
        logic [15:0] w_half;
        w_byte = rword[{lane, 3'b000} +: 8];
        w_half = lane[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: return uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: return uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: return rword;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [1:0] lane, input logic [1:0] size,
                                                input logic [31:0] rword, input logic [31:0] wdata);
        logic [31:0] w_word;
        w_word = rword;
        case (size)
            SZ_BYTE: w_word[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: w_word = lane[1] ? {wdata[15:0], rword[15:0]} : {rword[31:16], wdata[15:0]};
            default: w_word = wdata;
        endcase
        return w_word;
    endfunction

    assign o_load_data  = load_extract(i_lane, i_size, i_unsigned, i_rword);
    assign o_store_word = store_merge(i_lane, i_size, i_rword, i_wdata);

endmodule

// File: rtl/mem_lsu_master.sv
// rtl/mem_lsu_master.sv - load/store master to word RAM with range check and RMW; LSU_MISALIGN_TRAP_EN faults misaligned accesses
module mem_lsu_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] RAM_ORIGIN = 32'h100,
    parameter logic [31:0] RAM_LENGTH = 32'h08000
) (
    input  logic             iLSU_CLK,
    input  logic             iLSU_RST,
    mem_lsu_master_if.master bus
);

    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_RD   = RD;
    localparam logic [2:0] S_RMW  = RMW;
    localparam logic [2:0] S_WR   = WR;
    localparam logic [2:0] S_RESP = RESP;

    logic [2:0]  r_state;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_ram_ce;
    logic        r_ram_rd;
    logic        r_ram_wr;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_data;

    logic        w_req_ready;
    logic        w_accept;
    logic [32:0] w_req_end;
    logic [32:0] w_ram_limit;
    logic        w_in_range;
    logic        w_fault;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_req_ready = (r_state == S_IDLE) && !iLSU_RST;
    assign w_accept    = bus.iLSU_REQ_VALID && w_req_ready;

    // 33-bit bounds so an access wrapping past 32'hFFFFFFFF is out of range.
    assign w_req_end   = {1'b0, bus.iLSU_REQ_ADDR} + size_bytes(bus.iLSU_REQ_SIZE) - 33'd1;
    assign w_ram_limit = {1'b0, RAM_ORIGIN} + {1'b0, RAM_LENGTH};
    assign w_in_range  = (bus.iLSU_REQ_ADDR >= RAM_ORIGIN) && (w_req_end < w_ram_limit);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((bus.iLSU_REQ_SIZE == SZ_HALF) && bus.iLSU_REQ_ADDR[0]) ||
                        ((bus.iLSU_REQ_SIZE == SZ_WORD) && (bus.iLSU_REQ_ADDR[1:0] != 2'b00));
    assign w_fault    = !w_in_range || (bus.iLSU_REQ_SIZE == 2'd3) || w_misalign;
`else
    assign w_fault    = !w_in_range || (bus.iLSU_REQ_SIZE == 2'd3);
`endif

    lsu_data_align u_align (
        .i_lane       (r_lane),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_rword      (bus.iRAM_DATA),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // RAM strobes are set for the state being entered, so they are glitch-free flops.
    always_ff @(posedge iLSU_CLK) begin
        if (iLSU_RST) begin
            r_state     <= S_IDLE;
            r_lane      <= 2'b00;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_wdata     <= 32'h0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_ram_ce    <= 1'b0;
            r_ram_rd    <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_ram_addr  <= 32'h0;
            r_ram_data  <= 32'h0;
        end else begin
            r_ram_ce <= 1'b0;
            r_ram_rd <= 1'b0;
            r_ram_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lane      <= bus.iLSU_REQ_ADDR[1:0];
                        r_size      <= bus.iLSU_REQ_SIZE;
                        r_unsigned  <= bus.iLSU_REQ_UNSIGNED;
                        r_wdata     <= bus.iLSU_REQ_WDATA;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= w_fault;
                        if (w_fault) begin
                            r_state <= S_RESP;
                        end else begin
                            r_ram_addr <= {bus.iLSU_REQ_ADDR[31:2], 2'b00};
                            r_ram_ce   <= 1'b1;
                            if (!bus.iLSU_REQ_WE) begin
                                r_ram_rd <= 1'b1;
                                r_state  <= S_RD;
                            end else if (bus.iLSU_REQ_SIZE == SZ_WORD) begin
                                r_ram_wr   <= 1'b1;
                                r_ram_data <= bus.iLSU_REQ_WDATA;
                                r_state    <= S_WR;
                            end else begin
                                r_ram_rd <= 1'b1;
                                r_state  <= S_RMW;
                            end
                        end
                    end
                end
                S_RD: begin
                    r_rsp_rdata <= w_load_data;
                    r_state     <= S_RESP;
                end
                S_RMW: begin
                    r_ram_ce   <= 1'b1;
                    r_ram_wr   <= 1'b1;
                    r_ram_data <= w_store_word;
                    r_state    <= S_WR;
                end
                S_WR: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.iLSU_RSP_READY) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oLSU_REQ_READY = w_req_ready;
    assign bus.oLSU_RSP_VALID = (r_state == S_RESP);
    assign bus.oLSU_RSP_RDATA = r_rsp_rdata;
    assign bus.oLSU_RSP_ERR   = r_rsp_err;
    assign bus.oRAM_CE        = r_ram_ce;
    assign bus.oRAM_RD        = r_ram_rd;
    assign bus.oRAM_WR        = r_ram_wr;
    assign bus.oRAM_ADDR      = r_ram_addr;
    assign bus.oRAM_DATA      = r_ram_data;

endmodule

// File: tb/tb_mem_lsu_master.sv
// tb/tb_mem_lsu_master.sv - directed and random checks of mem_lsu_master against a byte-array reference model
module tb_mem_lsu_master;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   wr_pulses = 0;
    int   bus_viol = 0;

    always #5 clk = ~clk;

    mem_lsu_master_if bus();

    mem_lsu_master #(
        .RAM_ORIGIN (32'h100),
        .RAM_LENGTH (32'h8000)
    ) dut (
        .iLSU_CLK (clk),
        .iLSU_RST (rst),
        .bus      (bus)
    );

    logic [31:0] ram [0:8191];
    logic [7:0]  refm [0:32767];
    logic [31:0] roff;
    logic        rwin;

    assign roff = bus.oRAM_ADDR - 32'h100;
    assign rwin = roff < 32'h8000;
    assign bus.iRAM_DATA = (bus.oRAM_CE && bus.oRAM_RD && rwin) ? ram[roff[14:2]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (bus.oRAM_CE && bus.oRAM_WR && rwin) ram[roff[14:2]] <= bus.oRAM_DATA;
        if (bus.oRAM_CE && bus.oRAM_WR) wr_pulses++;
        if (bus.oRAM_RD && bus.oRAM_WR) bus_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] a);
        longint unsigned lo;
        longint unsigned n;
        lo = 64'(a);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3) return 1'b1;
        if (lo < 64'h100 || lo + n - 1 >= 64'h8100) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int o;
        o = int'(a - 32'h100) & ~3;
        return {refm[o+3], refm[o+2], refm[o+1], refm[o]};
    endfunction

    task automatic txn(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input string tag,
                       output logic [31:0] o_rd, output logic [31:0] o_wd, output logic o_err);
        logic        flt;
        logic [31:0] ea, exp_rd, exp_wd, rd_addr, wr_addr, wr_data, held;
        int          nb, o, exp_lat, lat, n, rd_cycles, wr_cycles;
        logic        saw_ce;
        flt = model_fault(sz, a);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ea = (sz == 2'd0) ? a : (sz == 2'd1) ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
        exp_lat = flt ? 1 : (!we || sz == 2'd2) ? 2 : 3;
        exp_rd = 32'h0;
        exp_wd = 32'h0;
        if (!flt) begin
            o = int'(ea - 32'h100);
            if (we) begin
                for (int k = 0; k < nb; k++) refm[o+k] = wd[8*k +: 8];
                exp_wd = word_at(ea);
            end else begin
                for (int k = 0; k < nb; k++) exp_rd = exp_rd | (32'(refm[o+k]) << (8*k));
                if (!uns && nb == 1 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFFFF00;
                if (!uns && nb == 2 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF0000;
            end
        end
        bus.iLSU_REQ_WE = we; bus.iLSU_REQ_SIZE = sz; bus.iLSU_REQ_UNSIGNED = uns;
        bus.iLSU_REQ_ADDR = a; bus.iLSU_REQ_WDATA = wd; bus.iLSU_REQ_VALID = 1'b1;
        n = 0;
        while (!bus.oLSU_REQ_READY && n < 20) begin @(negedge clk); n++; end
        check({tag, " req_ready"}, 32'(bus.oLSU_REQ_READY), 32'd1);
        @(posedge clk); #1;
        bus.iLSU_REQ_VALID = 1'b0;
        @(negedge clk);
        lat = 1; rd_cycles = 0; wr_cycles = 0; saw_ce = 1'b0;
        rd_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0;
        while (!bus.oLSU_RSP_VALID && lat < 10) begin
            if (bus.oRAM_CE) saw_ce = 1'b1;
            if (bus.oRAM_RD) begin rd_cycles++; rd_addr = bus.oRAM_ADDR; end
            if (bus.oRAM_WR) begin wr_cycles++; wr_addr = bus.oRAM_ADDR; wr_data = bus.oRAM_DATA; end
            @(negedge clk); lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(bus.oLSU_RSP_ERR), 32'(flt));
        check({tag, " rdata"}, bus.oLSU_RSP_RDATA, exp_rd);
        if (flt) begin
            check({tag, " no bus on fault"}, 32'(saw_ce), 32'd0);
        end else begin
            check({tag, " rd cycles"}, 32'(rd_cycles), (!we || sz != 2'd2) ? 32'd1 : 32'd0);
            check({tag, " wr cycles"}, 32'(wr_cycles), we ? 32'd1 : 32'd0);
            if (rd_cycles > 0) check({tag, " rd addr"}, rd_addr, {ea[31:2], 2'b00});
            if (we) begin
                check({tag, " wr addr"}, wr_addr, {ea[31:2], 2'b00});
                check({tag, " wr data"}, wr_data, exp_wd);
            end
        end
        o_rd = bus.oLSU_RSP_RDATA; o_wd = wr_data; o_err = bus.oLSU_RSP_ERR;
        held = bus.oLSU_RSP_RDATA;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 32'(bus.oLSU_RSP_VALID), 32'd1);
            check({tag, " hold rdata"}, bus.oLSU_RSP_RDATA, held);
            check({tag, " hold req_ready"}, 32'(bus.oLSU_REQ_READY), 32'd0);
            check({tag, " hold bus idle"}, 32'(bus.oRAM_CE), 32'd0);
        end
        bus.iLSU_RSP_READY = 1'b1;
        @(posedge clk); #1;
        bus.iLSU_RSP_READY = 1'b0;
        @(negedge clk);
        check({tag, " rsp done"}, 32'(bus.oLSU_RSP_VALID), 32'd0);
        check({tag, " back to idle"}, 32'(bus.oLSU_REQ_READY), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, wd, a, w;
        logic        er;
        int          r, wp;
        rst = 1'b1;
        bus.iLSU_REQ_VALID = 1'b0; bus.iLSU_REQ_WE = 1'b0; bus.iLSU_REQ_SIZE = 2'd0;
        bus.iLSU_REQ_UNSIGNED = 1'b0; bus.iLSU_REQ_ADDR = 32'h0; bus.iLSU_REQ_WDATA = 32'h0;
        bus.iLSU_RSP_READY = 1'b0;
        for (int i = 0; i < 8192; i++) begin
            w = (i == 0) ? 32'h8899AABB : $urandom;
            ram[i] = w;
            for (int k = 0; k < 4; k++) refm[4*i+k] = w[8*k +: 8];
        end
        @(negedge clk); @(negedge clk);
        check("rst req_ready", 32'(bus.oLSU_REQ_READY), 32'd0);
        check("rst rsp_valid", 32'(bus.oLSU_RSP_VALID), 32'd0);
        check("rst rdata", bus.oLSU_RSP_RDATA, 32'd0);
        check("rst err", 32'(bus.oLSU_RSP_ERR), 32'd0);
        check("rst strobes", {29'd0, bus.oRAM_CE, bus.oRAM_RD, bus.oRAM_WR}, 32'd0);
        check("rst ram addr", bus.oRAM_ADDR, 32'd0);
        check("rst ram data", bus.oRAM_DATA, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post rst req_ready", 32'(bus.oLSU_REQ_READY), 32'd1);

        txn(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 0, "lb 101", rd, wd, er);
        check("lb 101 value", rd, 32'hFFFFFFAA);
        txn(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 0, "lbu 101", rd, wd, er);
        check("lbu 101 value", rd, 32'h000000AA);
        txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, "lw 102", rd, wd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw 102 trap", 32'(er), 32'd1);
`else
        check("lw 102 aligned", rd, 32'h8899AABB);
`endif
        txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 0, "sh 102", rd, wd, er);
        check("sh 102 merged", wd, 32'h1234AABB);
        txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, "lw 100", rd, wd, er);
        check("lw 100 value", rd, 32'h1234AABB);
        txn(1'b0, 2'd2, 1'b0, 32'h0FC, 32'h0, 0, "lw 0fc", rd, wd, er);
        check("lw 0fc err", 32'(er), 32'd1);
        txn(1'b0, 2'd2, 1'b0, 32'h80FC, 32'h0, 0, "lw 80fc", rd, wd, er);
        check("lw 80fc err", 32'(er), 32'd0);
        txn(1'b0, 2'd1, 1'b0, 32'h80FF, 32'h0, 0, "lh 80ff", rd, wd, er);
        check("lh 80ff err", 32'(er), 32'd1);
        txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, "lw hold", rd, wd, er);
        txn(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0, "lhu b2b", rd, wd, er);
        check("lhu b2b value", rd, 32'h00001234);

        bus.iLSU_REQ_WE = 1'b1; bus.iLSU_REQ_SIZE = 2'd0; bus.iLSU_REQ_UNSIGNED = 1'b0;
        bus.iLSU_REQ_ADDR = 32'h105; bus.iLSU_REQ_WDATA = 32'h55; bus.iLSU_REQ_VALID = 1'b1;
        @(posedge clk); #1;
        bus.iLSU_REQ_VALID = 1'b0;
        @(negedge clk);
        check("rmw read cycle", {29'd0, bus.oRAM_CE, bus.oRAM_RD, bus.oRAM_WR}, 32'b110);
        rst = 1'b1;
        wp = wr_pulses;
        @(posedge clk);
        @(negedge clk);
        check("rmw rst strobes", {29'd0, bus.oRAM_CE, bus.oRAM_RD, bus.oRAM_WR}, 32'd0);
        check("rmw rst ram addr", bus.oRAM_ADDR, 32'd0);
        check("rmw rst rsp_valid", 32'(bus.oLSU_RSP_VALID), 32'd0);
        check("rmw rst req_ready", 32'(bus.oLSU_REQ_READY), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rmw rst no write", 32'(wr_pulses), 32'(wp));
        check("rmw rst ram word", ram[1], word_at(32'h104));
        check("rmw rst ready", 32'(bus.oLSU_REQ_READY), 32'd1);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       a = 32'h100 + $urandom_range(0, 63);
            else if (r < 7)  a = 32'hF0 + $urandom_range(0, 31);
            else if (r < 9)  a = 32'h80F0 + $urandom_range(0, 31);
            else             a = 32'hFFFFFFFC + $urandom_range(0, 3);
            txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, int'($urandom_range(0, 2)),
                $sformatf("rnd%0d", i), rd, wd, er);
        end

        for (int i = 0; i < 16; i++) begin
            check($sformatf("ram word %0d", i), ram[i], word_at(32'h100 + 32'(4*i)));
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ram top word %0d", i), ram[8184+i], word_at(32'h80E0 + 32'(4*i)));
        end
        check("rd/wr never together", 32'(bus_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu_master.md
Name: mem_lsu_master

Overview:
Load/store initiator that sits between the core's load/store stage and the word-organised RAM responder. It drives the RAM's CE/RD/WR/ADDR/DATA strobes. It converts byte, halfword and word accesses into word-bus cycles, using read-modify-write for sub-word stores. It also range-checks addresses and returns sign/zero-extended load data over a valid/ready handshake.

Parameters:
RAM_ORIGIN, 32'h100, base byte address of the RAM window
RAM_LENGTH, 32'h08000, RAM window size in bytes; legal range is [RAM_ORIGIN, RAM_ORIGIN+RAM_LENGTH)

Ports:
iLSU_CLK  in  1  clock; single clock domain
iLSU_RST  in  1  synchronous reset, active-high
iLSU_REQ_VALID  in  1  request valid
oLSU_REQ_READY  out  1  request accepted when VALID&READY at a rising edge
iLSU_REQ_WE  in  1  1=store, 0=load
iLSU_REQ_SIZE  in  2  0=byte, 1=half, 2=word; 3 is illegal and returns an error
iLSU_REQ_UNSIGNED  in  1  load zero-extend when 1, sign-extend when 0
iLSU_REQ_ADDR  in  32  byte address
iLSU_REQ_WDATA  in  32  store data, right-justified
oLSU_RSP_VALID  out  1  response valid; held until accepted
iLSU_RSP_READY  in  1  core accepts response
oLSU_RSP_RDATA  out  32  extended load data; 0 for stores and errors
oLSU_RSP_ERR  out  1  access fault
oRAM_CE  out  1  chip enable
oRAM_RD  out  1  read enable
oRAM_WR  out  1  write enable; RAM writes on the rising edge
oRAM_ADDR  out  32  word-aligned byte address, {addr[31:2],2'b00}
oRAM_DATA  out  32  write word
iRAM_DATA  in  32  combinational read word, valid in the same cycle as CE&RD

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; the clock and reset ports are iLSU_CLK and iLSU_RST.
- Reset values: state=IDLE; REQ_READY=0 in the reset cycle and 1 from the following cycle; RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0; RAM CE/RD/WR=0, ADDR=0, DATA=0.
- All RAM outputs are registered, so no strobe glitches appear.
- Request capture: on acceptance, addr, size, we, unsigned and wdata are registered.
- Fault check at acceptance:
  - Fault = out-of-range, OR size==3, OR misaligned when LSU_MISALIGN_TRAP_EN is defined.
  - Range test uses full 32-bit compares. The access is in range only if addr>=RAM_ORIGIN and addr+bytes-1 < RAM_ORIGIN+RAM_LENGTH. Bound arithmetic is 33-bit, so wrap-around at 32'hFFFFFFFF counts as out of range.
- FSM states and transitions:
  - IDLE: READY=1. Accept request, then go to:
    - fault -> RESP with ERR=1 (no RAM cycle)
    - load -> RD
    - store of size==2 -> WR
    - store of size 0/1 -> RMW
  - RD: CE=RD=1. iRAM_DATA is sampled at the end of the cycle, lane-extracted and extended into RSP_RDATA. Next state is RESP.
  - RMW: CE=RD=1. At the end of the cycle, the new byte or half is merged into iRAM_DATA to form the write word. Next state is WR.
  - WR: CE=WR=1, DATA=write word. Next state is RESP.
  - RESP: RSP_VALID=1 and READY=0. Leave to IDLE when RSP_READY=1.
- Bus rules:
  - CE/RD/WR are deasserted in IDLE and RESP.
  - RD and WR are never asserted together.
- Latency, measured from the acceptance edge T0 to the first cycle with RSP_VALID:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - fault: 1 cycle
- Throughput: at most one outstanding request. The next request can be accepted in the cycle after the response handshake, when the FSM is back in IDLE.
- Lanes are little-endian:
  - byte lane = addr[1:0]
  - half lane = addr[1]
  - sign bit is bit 7 (byte) or bit 15 (half) of the extracted field
- Reset mid-operation: the bus is idle in the first cycle after reset. An RMW interrupted before WR must never write. A pending response is discarded.
- If RSP_READY=1 in the cycle RSP_VALID first rises, the response completes in that single cycle.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a half at an odd address or a word with addr[1:0]!=0 is a fault. ERR=1, and there is no RAM cycle.
- Undefined: misaligned accesses are silently aligned down. Half uses addr[1]; word uses {addr[31:2],2'b00}. ERR stays 0.

Decomposition:
- Package lsu_pkg holds:
  - size encodings: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2
  - FSM state enum: IDLE, RD, RMW, WR, RESP
- Sub-module lsu_data_align is purely combinational, with two functions:
  - load path: extract and sign/zero-extend a lane
  - store path: merge a byte or half into a read word
- The FSM and range check stay in mem_lsu_master.

Test Plan:
- Setup: RAM word at 0x100 = 0x8899AABB.
- LB at 0x101 (signed) -> RDATA=0xFFFFFFAA, ERR=0, RSP_VALID 2 cycles after accept. LBU at 0x101 -> 0x000000AA.
- SH of 0x1234 at 0x102 -> RMW read cycle, then WR with DATA=0x1234AABB at ADDR=0x100, RSP at T0+3. A following LW at 0x100 -> 0x1234AABB.
- LW at 0x0FC -> ERR=1 at T0+1, CE never asserted. LW at 0x80FC -> ERR=0. LH at 0x80FF -> ERR=1 (crosses the upper bound).
- LW at 0x102: with LSU_MISALIGN_TRAP_EN -> ERR=1, no bus cycle; without it -> RDATA=0x8899AABB from ADDR=0x100.
- Hold RSP_READY=0 for 3 cycles -> RSP_VALID and RDATA stay stable, REQ_READY=0, bus idle. Then RSP_READY=1 -> IDLE next cycle, back-to-back request accepted.
- Assert RST during the RMW cycle of an SB -> no WR pulse, all outputs at reset values the next cycle, RAM contents unchanged.
